qdiv_arbiter: RTL
=================

# qdiv_arbiter

Round-robin scheduler that shares one sequential Q-format fixed-point divider (`floating_div_32b`-style datapath, sign-magnitude, N bits with Q fractional bits) among NREQ requesters. It accepts one division job at a time via valid/ready, sequences the divider's start/complete protocol, and returns the quotient and overflow flag to the originating requester via per-requester valid/ready. The block sits between compute lanes and a single divider instance, with one job outstanding.

## Interface
- N, 32, operand/quotient width (bit N-1 = sign, bits N-2:0 = magnitude)
- Q, 15, fractional bits; determines divider latency
- NREQ, 4, number of requesters (2..8)
- IDW, 2, grant-id width; NREQ <= 2**IDW
- i_clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  NREQ  per-requester job valid
- o_req_ready  out  NREQ  one-hot accept; at most one bit high
- i_req_dividend  in  NREQ*N  flattened; requester k at [k*N +: N]
- i_req_divisor  in  NREQ*N  flattened, same packing
- o_rsp_valid  out  NREQ  one-hot result valid
- i_rsp_ready  in  NREQ  per-requester result accept
- o_rsp_quotient  out  N  shared result bus, valid while any o_rsp_valid bit is high
- o_rsp_overflow  out  1  overflow for the current result
- o_div_start  out  1  divider start pulse
- o_div_dividend  out  N  divider dividend
- o_div_divisor  out  N  divider divisor
- i_div_quotient  in  N  divider quotient
- i_div_complete  in  1  divider done/idle flag
- i_div_overflow  in  1  divider overflow flag
- o_busy  out  1  high in any state except IDLE
- o_grant_id  out  IDW  index of the job in flight; holds its last value in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if i_div_complete=1 and any i_req_valid is set, select g by round-robin: search starts at last_grant+1 mod NREQ. o_req_ready[g]=1 combinationally. On the handshake edge, latch the operands, set o_grant_id=g and last_grant=g, then go to ISSUE. If i_div_complete=0, no grant is made (divider not idle).
- ISSUE: o_div_start=1 for exactly one cycle. Latched operands are driven on o_div_dividend/o_div_divisor, and these hold stable through WAIT. Next state is WAIT.
- WAIT: on the first cycle with i_div_complete=1, capture i_div_quotient and i_div_overflow into result registers and go to RESP.
- RESP: o_rsp_valid[o_grant_id]=1. o_rsp_quotient and o_rsp_overflow are held stable. On i_rsp_ready[o_grant_id]=1, go to IDLE. Ready bits of other requesters are ignored.
- Only one job is outstanding. A stalled response blocks all new grants.
- A requester may drop i_req_valid before it is granted; no state is affected.
- A requester may have a new request pending while its response is pending. It is granted only after return to IDLE.
- No arithmetic is done on operands; they are passed through unchanged.

## Timing
- Reset values:
  - state=IDLE, last_grant=NREQ-1 (requester 0 wins first), o_grant_id=0
  - o_req_ready=0 (forced 0 while rst high), o_rsp_valid=0, o_rsp_quotient=0, o_rsp_overflow=0
  - o_div_start=0, o_div_dividend=0, o_div_divisor=0, o_busy=0
- Latency: the accept edge is E0. Start is sampled by the divider at E1. Divider complete returns after N+Q cycles of busy. The result is captured at E(N+Q+2), and o_rsp_valid is high from that edge, i.e. 49 cycles with defaults.
- Back-to-back throughput: one job per N+Q+3 cycles plus response stall cycles.
- i_div_complete is low in the WAIT cycle after ISSUE, and the FSM relies on this. The quotient is sampled only when complete=1 in WAIT.
- Reset mid-operation: an async return to IDLE drops the job and drops any pending response. The divider must share the same reset. If it does not, the IDLE guard on i_div_complete prevents a start while the divider is busy.

## Configuration
- QDIV_ARB_DIVZERO_EN defined:
  - At acceptance, if divisor[N-2:0]==0, skip ISSUE/WAIT and enter RESP on the next edge with no o_div_start.
  - The result is quotient = {dividend[N-1]^divisor[N-1], all ones magnitude} and overflow=1.
  - Latency is 1 cycle.
- Undefined: zero-divisor jobs are forwarded to the divider like any other job, and the divider's quotient/overflow is returned unchanged.

## Test plan
- Reset, then requester 0 sends 0x00018000 / 0x00008000 (3.0/1.0) -> one o_div_start pulse; o_rsp_valid[0] 49 cycles after accept; quotient 0x00018000, overflow 0.
- All four valid continuously with i_rsp_ready held high -> grant order 0,1,2,3,0; o_req_ready always one-hot; no requester starved.
- Hold i_rsp_ready[2] low for 20 cycles while requester 2's result is pending -> quotient stable, no o_div_start, no grant; release -> IDLE, then next grant to requester 3.
- Assert rst during WAIT -> all outputs at reset values immediately (async); after release, requester 0 wins first.
- Divisor 0x80000000, dividend 0x00010000 -> with QDIV_ARB_DIVZERO_EN, o_rsp_valid one cycle after accept, quotient 0xFFFFFFFF, overflow 1, no start. Without it, a normal 49-cycle path returning the divider's output.
- Tie i_div_complete low in IDLE with requests pending -> o_req_ready stays 0; raise it -> grant on that cycle.

Source files
------------

// File: rtl/qdiv_arbiter_if.sv
// qdiv_arbiter_if
//   Bundles the signals between qdiv_arbiter, its NREQ requesters and the
//   shared sequential divider.
//   slave  : arbiter side (drives o_*, samples i_*)
//   master : environment side (requesters + divider; drives i_*, samples o_*)
//
//   Requester side: i_req_valid / o_req_ready (one-hot accept), flattened
//   operands i_req_dividend / i_req_divisor (requester k at [k*N +: N]),
//   o_rsp_valid / i_rsp_ready (one-hot), o_rsp_quotient, o_rsp_overflow.
//   Divider side: o_div_start, o_div_dividend, o_div_divisor,
//   i_div_quotient, i_div_complete (done/idle), i_div_overflow.
//   Status: o_busy, o_grant_id.

interface qdiv_arbiter_if #(
   parameter int N    = 32,
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   i_req_valid;
   logic [NREQ-1:0]   o_req_ready;
   logic [NREQ*N-1:0] i_req_dividend;
   logic [NREQ*N-1:0] i_req_divisor;
   logic [NREQ-1:0]   o_rsp_valid;
   logic [NREQ-1:0]   i_rsp_ready;
   logic [N-1:0]      o_rsp_quotient;
   logic              o_rsp_overflow;
   logic              o_div_start;
   logic [N-1:0]      o_div_dividend;
   logic [N-1:0]      o_div_divisor;
   logic [N-1:0]      i_div_quotient;
   logic              i_div_complete;
   logic              i_div_overflow;
   logic              o_busy;
   logic [IDW-1:0]    o_grant_id;

   modport slave (
      input  i_req_valid, i_req_dividend, i_req_divisor, i_rsp_ready,
             i_div_quotient, i_div_complete, i_div_overflow,
      output o_req_ready, o_rsp_valid, o_rsp_quotient, o_rsp_overflow,
             o_div_start, o_div_dividend, o_div_divisor, o_busy, o_grant_id
   );

   modport master (
      output i_req_valid, i_req_dividend, i_req_divisor, i_rsp_ready,
             i_div_quotient, i_div_complete, i_div_overflow,
      input  o_req_ready, o_rsp_valid, o_rsp_quotient, o_rsp_overflow,
             o_div_start, o_div_dividend, o_div_divisor, o_busy, o_grant_id
   );
endinterface

// File: rtl/qdiv_arbiter.sv
// qdiv_arbiter
//   Round-robin scheduler sharing one sequential sign-magnitude Q-format
//   divider among NREQ requesters, one job outstanding at a time. Operands
//   and results are passed through untouched.
//
//   Ports:
//     i_clk  rising-edge clock
//     rst    asynchronous active-high reset (divider should share it)
//     bus    qdiv_arbiter_if.slave: requester handshakes, divider
//            start/complete protocol, o_busy, o_grant_id
//
//   Optional build macro QDIV_ARB_DIVZERO_EN: a job whose divisor magnitude
//   is zero bypasses the divider and returns a saturated quotient with
//   overflow=1 directly from acceptance. Without it such jobs go to the
//   divider like any other.
//
//   state | meaning
//   IDLE  | waiting for a request while the divider reports idle
//   ISSUE | one-cycle start pulse, latched operands on the divider bus
//   WAIT  | divider busy; capture result on first complete=1
//   RESP  | result held on the bus for the granted requester

module qdiv_arbiter #(
   parameter int N    = 32,
   parameter int Q    = 15,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic          i_clk,
   input  logic          rst,
   qdiv_arbiter_if.slave bus
);

   if (NREQ < 2 || NREQ > 8 || NREQ > (1 << IDW) || Q < 0 || Q >= N) begin : g_cfg_check
      $error("qdiv_arbiter: unsupported parameter set");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  last_grant, grant_id;
   logic [IDW-1:0]  pick, cand;
   logic            pick_vld;
   logic            accept, div_zero;
   logic [N-1:0]    sel_dd, sel_dv;
   logic [N-1:0]    op_dd, op_dv;
   logic [N-1:0]    res_q;
   logic            res_ov;
   logic [NREQ-1:0] req_ready, rsp_valid;
   logic            div_start;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = IDW'((int'(last_grant) + i) % NREQ);
         if (!pick_vld && bus.i_req_valid[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   assign sel_dd = bus.i_req_dividend[int'(pick)*N +: N];
   assign sel_dv = bus.i_req_divisor[int'(pick)*N +: N];

`ifdef QDIV_ARB_DIVZERO_EN
   assign div_zero = (sel_dv[N-2:0] == '0);
`else
   assign div_zero = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      div_start = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            // complete=1 doubles as "divider idle"; never start a busy divider.
            if (bus.i_div_complete && pick_vld && !rst) begin
               req_ready[pick] = 1'b1;
               accept          = 1'b1;
               state_nxt       = div_zero ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.i_div_complete) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
            if (bus.i_rsp_ready[grant_id]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         last_grant <= IDW'(NREQ - 1);
         grant_id   <= '0;
         op_dd      <= '0;
         op_dv      <= '0;
         res_q      <= '0;
         res_ov     <= 1'b0;
      end else begin
         if (accept) begin
            op_dd      <= sel_dd;
            op_dv      <= sel_dv;
            grant_id   <= pick;
            last_grant <= pick;
`ifdef QDIV_ARB_DIVZERO_EN
            if (div_zero) begin
               res_q  <= {sel_dd[N-1] ^ sel_dv[N-1], {(N-1){1'b1}}};
               res_ov <= 1'b1;
            end
`endif
         end
         if (state == WAIT && bus.i_div_complete) begin
            res_q  <= bus.i_div_quotient;
            res_ov <= bus.i_div_overflow;
         end
      end
   end

   assign bus.o_req_ready    = req_ready;
   assign bus.o_rsp_valid    = rsp_valid;
   assign bus.o_rsp_quotient = res_q;
   assign bus.o_rsp_overflow = res_ov;
   assign bus.o_div_start    = div_start;
   assign bus.o_div_dividend = op_dd;
   assign bus.o_div_divisor  = op_dv;
   assign bus.o_busy         = (state != IDLE);
   assign bus.o_grant_id     = grant_id;

endmodule
